// File: rtl/channel_pkg.sv
// Shared constants for the channel voice: register offsets,
// wave type encodings, phase width and LFSR seed.
package channel_pkg;

    localparam int PHASE_W = 24;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam logic [3:0] REG_CTRL    = 4'h0;
    localparam logic [3:0] REG_FREQ_LO = 4'h1;
    localparam logic [3:0] REG_FREQ_HI = 4'h2;
    localparam logic [3:0] REG_PW      = 4'h3;
    localparam logic [3:0] REG_VOL     = 4'h4;
    localparam logic [3:0] REG_SAMPLE  = 4'h5;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_PULSE = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_t;

endpackage

// File: rtl/channel_bus_if.sv
// Bus front end: BusClock synchroniser, write strobe, address decode, read drive.
// Ports: Clock, Reset, BusAddress, BusData, BusReadWrite, BusClock, rdata -> wr_en, offset, wdata.
module channel_bus_if #(
    parameter logic [15:0] ADDR = 16'h0010
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] BusAddress,
    inout  wire  [7:0]  BusData,
    input  logic        BusReadWrite,
    input  logic        BusClock,
    input  logic [7:0]  rdata,
    output logic        wr_en,
    output logic [3:0]  offset,
    output logic [7:0]  wdata
);

    // [0],[1] synchronise; [2] holds the previous synchronised level.
    logic [2:0] sync;
    logic       sel;
    logic       wr_stb;

    // Reset to all-ones so a strobe still high when Reset releases
    // is not seen as a fresh rising edge: the aborted write stays dead.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], BusClock};
        end
    end

    assign wr_stb = sync[1] & ~sync[2];
    assign sel    = (BusAddress[15:4] == ADDR[15:4]);
    assign wr_en  = wr_stb & sel & ~BusReadWrite;
    assign offset = BusAddress[3:0];
    assign wdata  = BusData;

    assign BusData = (Reset && sel && BusReadWrite && BusClock) ? rdata : 8'hzz;

endmodule

// File: rtl/channel.sv
// One synth voice: saw/pulse/triangle (+noise with CHANNEL_NOISE_EN) scaled by VOL.
// Ports: Clock, Reset (async low), BusAddress/BusData/BusReadWrite/BusClock, Waveform.
module channel
    import channel_pkg::*;
#(
    parameter int          WAVE_DEPTH = 8,
    parameter logic [15:0] ADDR       = 16'h0010
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           BusAddress,
    inout  wire  [7:0]            BusData,
    input  logic                  BusReadWrite,
    input  logic                  BusClock,
    output logic [WAVE_DEPTH-1:0] Waveform
);

    localparam int W = WAVE_DEPTH;

    logic               wr_en;
    logic [3:0]         offset;
    logic [7:0]         wdata;
    logic [7:0]         rdata;
    logic [7:0]         sample;

    logic               en;
    wave_t              wtype;
    logic [15:0]        inc;
    logic [7:0]         pw;
    logic [7:0]         vol;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;
    logic               prst;

    logic [W-1:0]       raw;
    logic [W-1:0]       noise_raw;
    logic [W:0]         tri_p;
    logic [W+7:0]       prod;

    channel_bus_if #(.ADDR(ADDR)) u_bus (
        .Clock        (Clock),
        .Reset        (Reset),
        .BusAddress   (BusAddress),
        .BusData      (BusData),
        .BusReadWrite (BusReadWrite),
        .BusClock     (BusClock),
        .rdata        (rdata),
        .wr_en        (wr_en),
        .offset       (offset),
        .wdata        (wdata)
    );

    assign prst = wr_en && (offset == REG_CTRL) && wdata[7];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            en    <= 1'b0;
            wtype <= WAVE_SAW;
            inc   <= '0;
            pw    <= '0;
            vol   <= '0;
        end else if (wr_en) begin
            unique case (1'b1)
                (offset == REG_CTRL): begin
                    en    <= wdata[0];
                    wtype <= wave_t'(wdata[2:1]);
                end
                (offset == REG_FREQ_LO): inc[7:0]  <= wdata;
                (offset == REG_FREQ_HI): inc[15:8] <= wdata;
                (offset == REG_PW):      pw        <= wdata;
                (offset == REG_VOL):     vol       <= wdata;
                default: ;
            endcase
        end
    end

`ifdef CHANNEL_NOISE_EN
    logic        carry;
    logic [15:0] lfsr;

    assign {carry, phase_nxt} = {1'b0, phase} + {9'b0, inc};

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lfsr <= LFSR_SEED;
        end else if (carry && en) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign noise_raw = lfsr[15 -: W];
`else
    assign phase_nxt = phase + {8'b0, inc};
    assign noise_raw = '0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            phase <= '0;
        end else if (prst) begin
            phase <= '0;
        end else if (en) begin
            phase <= phase_nxt;
        end
    end

    assign tri_p = phase[PHASE_W-1 -: W+1];

    always_comb begin
        raw = '0;
        unique case (wtype)
            WAVE_SAW:   raw = phase[PHASE_W-1 -: W];
            WAVE_PULSE: raw = (phase[23:16] < pw) ? '1 : '0;
            WAVE_TRI:   raw = tri_p[W] ? ~tri_p[W-1:0] : tri_p[W-1:0];
            WAVE_NOISE: raw = noise_raw;
            default:    raw = '0;
        endcase
    end

    assign prod = {8'h00, raw} * {{W{1'b0}}, vol};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Waveform <= '0;
        end else begin
            Waveform <= en ? prod[W+7:8] : '0;
        end
    end

    generate
        if (W >= 8) begin : g_samp_wide
            assign sample = Waveform[W-1 -: 8];
        end else begin : g_samp_narrow
            assign sample = {Waveform, {(8-W){1'b0}}};
        end
    endgenerate

    always_comb begin
        rdata = 8'h00;
        unique case (1'b1)
            (offset == REG_CTRL):    rdata = {5'b0, wtype, en};
            (offset == REG_FREQ_LO): rdata = inc[7:0];
            (offset == REG_FREQ_HI): rdata = inc[15:8];
            (offset == REG_PW):      rdata = pw;
            (offset == REG_VOL):     rdata = vol;
            (offset == REG_SAMPLE):  rdata = sample;
            default:                 rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_channel.sv
// Self-checking bench for channel: directed register tests plus randomized
// voice settings checked cycle by cycle against a behavioural model.
module tb_channel;

    localparam int W    = 8;
    localparam int FULL = (1 << W) - 1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] BusAddress = 16'h0;
    wire  [7:0]  BusData;
    logic        BusReadWrite = 1'b0;
    logic        BusClock = 1'b0;
    logic [W-1:0] Waveform;
    logic        tb_oe = 1'b0;
    logic [7:0]  tb_data = 8'h0;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_phase, m_inc, m_pw, m_vol, m_type, m_en, m_lfsr, m_wave;
    int wr_pend, wr_age, wr_off, wr_dat;

    assign BusData = tb_oe ? tb_data : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pu (BusData[g]);
    end

    channel #(.WAVE_DEPTH(W), .ADDR(16'h0010)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .BusAddress   (BusAddress),
        .BusData      (BusData),
        .BusReadWrite (BusReadWrite),
        .BusClock     (BusClock),
        .Waveform     (Waveform)
    );

    always #5 Clock = ~Clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_inc = 0; m_pw = 0; m_vol = 0;
        m_type = 0; m_en = 0; m_wave = 0;
        m_lfsr = 16'hACE1;
        wr_pend = 0; wr_age = 0;
    endtask

    function automatic int raw_of();
        int p;
        case (m_type)
            0: return m_phase >> (24 - W);
            1: return ((m_phase >> 16) < m_pw) ? FULL : 0;
            2: begin
                p = m_phase >> (23 - W);
                return (p > FULL) ? (2 * FULL + 1 - p) : p;
            end
            default: begin
`ifdef CHANNEL_NOISE_EN
                return m_lfsr >> (16 - W);
`else
                return 0;
`endif
            end
        endcase
    endfunction

    function automatic int read_exp(input int off);
        case (off)
            0: return (m_type << 1) | m_en;
            1: return m_inc & 8'hFF;
            2: return m_inc >> 8;
            3: return m_pw;
            4: return m_vol;
            5: return m_wave;
            default: return 0;
        endcase
    endfunction

    // One clock: advance the model by the rules, then compare Waveform.
    task automatic tick();
        int nw, sum, fb, commit;
        @(posedge Clock);
        nw  = m_en ? (raw_of() * m_vol) >> 8 : 0;
        sum = m_phase + m_inc;
        if (m_en && sum >= (1 << 24)) begin
            fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
        end
        commit = 0;
        if (wr_pend != 0) begin
            wr_age++;
            if (wr_age == 3) begin
                commit = 1;
                wr_pend = 0;
            end
        end
        if (commit != 0 && wr_off == 0 && wr_dat[7])
            m_phase = 0;
        else if (m_en != 0)
            m_phase = sum % (1 << 24);
        if (commit != 0) begin
            case (wr_off)
                0: begin m_en = wr_dat & 1; m_type = (wr_dat >> 1) & 3; end
                1: m_inc = (m_inc & 16'hFF00) | wr_dat;
                2: m_inc = (m_inc & 16'h00FF) | (wr_dat << 8);
                3: m_pw = wr_dat;
                4: m_vol = wr_dat;
                default: ;
            endcase
        end
        m_wave = nw;
        #1;
        chk("wave", 32'(Waveform), 32'(m_wave));
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge Clock);
        BusAddress   = addr;
        tb_data      = data;
        tb_oe        = 1'b1;
        BusReadWrite = 1'b0;
        BusClock     = 1'b1;
        if (addr[15:4] == 12'h001) begin
            wr_pend = 1; wr_age = 0;
            wr_off = int'(addr[3:0]); wr_dat = int'(data);
        end
        repeat (5) tick();
        BusClock = 1'b0;
        tb_oe    = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        BusAddress   = addr;
        BusReadWrite = 1'b1;
        BusClock     = 1'b1;
        #1;
        data = BusData;
        BusClock     = 1'b0;
        BusReadWrite = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [15:0] addr);
        logic [7:0] d;
        int exp;
        bus_read(addr, d);
        exp = (addr[15:4] == 12'h001) ? read_exp(int'(addr[3:0])) : 8'hFF;
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [7:0] d;
        int n;
        model_reset();

        // Reset with bus activity
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_wave", 32'(Waveform), 32'h0);
        bus_read(16'h0010, d);
        chk("rst_busz", 32'(d), 32'hFF);
        @(negedge Clock);
        BusAddress = 16'h0014; tb_data = 8'h55; tb_oe = 1'b1;
        BusReadWrite = 1'b0; BusClock = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        run(4);
        BusClock = 1'b0; tb_oe = 1'b0;
        tick();
        for (int a = 0; a < 6; a++) read_chk("rst_reg", 16'h0010 + 16'(a));
        read_chk("rst_reg_f", 16'h001F);

        // Register read/write
        bus_write(16'h0010, 8'h03);
        bus_write(16'h0011, 8'h00);
        bus_write(16'h0012, 8'h01);
        bus_write(16'h0013, 8'h80);
        bus_write(16'h0014, 8'hFF);
        for (int a = 0; a < 5; a++) read_chk("rw_reg", 16'h0010 + 16'(a));
        run(40);
        read_chk("sample", 16'h0015);
        read_chk("undef", 16'h001F);
        bus_write(16'h0020, 8'h05);
        read_chk("outside", 16'h0020);
        read_chk("ctrl_kept", 16'h0010);

        // Saw, slow then fast with wraps
        bus_write(16'h0010, 8'h01);
        run(600);
        bus_write(16'h0011, 8'hFF);
        bus_write(16'h0012, 8'hFF);
        run(540);

        // Pulse at PW 40, 00, FF
        bus_write(16'h0013, 8'h40);
        bus_write(16'h0010, 8'h03);
        run(520);
        bus_write(16'h0013, 8'h00);
        run(300);
        bus_write(16'h0013, 8'hFF);
        run(300);

        // Triangle at half volume, freeze and resume
        bus_write(16'h0014, 8'h80);
        bus_write(16'h0010, 8'h05);
        run(520);
        bus_write(16'h0010, 8'h04);
        run(20);
        bus_write(16'h0010, 8'h05);
        run(300);

        // Phase reset
        bus_write(16'h0010, 8'h85);
        read_chk("prst_ctrl", 16'h0010);
        run(100);

        // Randomized voice settings
        for (int r = 0; r < 6; r++) begin
            bus_write(16'h0011, 8'($urandom));
            bus_write(16'h0012, 8'($urandom_range(8'h20, 8'hFF)));
            bus_write(16'h0013, 8'($urandom));
            bus_write(16'h0014, 8'($urandom));
            bus_write(16'h0010, 8'(1 | ($urandom_range(0, 3) << 1)));
            run(300);
            read_chk("rnd_sample", 16'h0015);
            read_chk("rnd_freq", 16'h0012);
        end

        // Noise from a fresh reset
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        #1;
        chk("rst2_wave", 32'(Waveform), 32'h0);
        @(negedge Clock);
        Reset = 1'b1;
        bus_write(16'h0014, 8'hFF);
        bus_write(16'h0011, 8'hFF);
        bus_write(16'h0012, 8'hFF);
        bus_write(16'h0010, 8'h07);
`ifdef CHANNEL_NOISE_EN
        chk("noise_seed", 32'(Waveform), 32'hAB);
        n = 0;
        while (Waveform == 8'hAB && n < 400) begin
            tick();
            n++;
        end
        chk("noise_step", 32'(Waveform), 32'h55);
`else
        chk("noise_off", 32'(Waveform), 32'h0);
        run(300);
        chk("noise_off_end", 32'(Waveform), 32'h0);
`endif
        run(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel.md
Name: channel

Overview:
- One synthesizer voice: a bus-programmable waveform generator with saw, pulse and triangle shapes, plus noise when compiled in.
- Owns a 16-byte register window at ADDR on the shared 8-bit parallel bus.
- Produces a WAVE_DEPTH-bit, volume-scaled sample every Clock.
- Top level instantiates several channels at different ADDR values and sums their Waveform outputs.

Parameters:
- WAVE_DEPTH, 8, sample width in bits; legal range 4..16.
- ADDR, 16'h0010, base address of the register window; must be 16-byte aligned.

Ports:
- Clock  in  1  system clock; all state is in this domain.
- Reset  in  1  asynchronous, active-low reset.
- BusAddress  in  16  bus address.
- BusData  inout  8  bidirectional bus data.
- BusReadWrite  in  1  1 = read, 0 = write.
- BusClock  in  1  bus strobe; asynchronous to Clock; address, data and direction are stable while it is high.
- Waveform  out  WAVE_DEPTH  registered output sample.

Behaviour:
- Clocking and reset:
  - One clock (Clock); Reset is asynchronous, active-low.
  - Reset clears all registers, the phase accumulator and Waveform to 0; BusData is released (Z).
  - Reset asserted mid-write aborts the write.
- Bus window and select:
  - Window is ADDR..ADDR+15; sel = (BusAddress[15:4] == ADDR[15:4]).
- Bus strobe synchronisation:
  - BusClock passes through a 2-flop synchroniser; a rising-edge detect gives wr_stb.
- Writes:
  - On wr_stb, if sel and BusReadWrite==0, BusData is latched into the register at offset BusAddress[3:0].
  - Register updates within 3 Clock cycles of BusClock rising.
  - Writes to undefined or read-only offsets are ignored.
- Reads:
  - BusData is driven combinationally when sel && BusReadWrite==1 && BusClock==1; otherwise Z.
  - Undefined offsets read 8'h00.
- Register map (offset: name, reset 0):
  - 0x0 CTRL: bit0 EN; bits2:1 TYPE (0 saw, 1 pulse, 2 triangle, 3 noise); bit7 PRST, write-1 clears the phase accumulator, self-clearing, reads 0.
  - 0x1 FREQ_LO, 0x2 FREQ_HI: 16-bit phase increment INC.
  - 0x3 PW: pulse width.
  - 0x4 VOL: volume, 8'hFF ≈ full scale.
  - 0x5 SAMPLE, read-only: Waveform[WAVE_DEPTH-1 -: 8], zero-padded on the right if WAVE_DEPTH<8.
- Phase accumulator:
  - 24-bit phase; phase <= phase + INC every Clock while EN=1.
  - Wraps modulo 2^24; held while EN=0.
  - PRST takes priority over the increment in the same cycle.
  - carry = carry out of the add.
- Raw sample (width W = WAVE_DEPTH), with p = phase[23 -: W+1]:
  - saw: raw = phase[23 -: W].
  - pulse: raw = (phase[23:16] < PW) ? all-ones : 0. PW=0 gives constant 0; PW=8'hFF gives high except when phase[23:16]==8'hFF.
  - triangle: raw = p[W] ? ~p[W-1:0] : p[W-1:0].
  - noise: see Optional Feature.
- Output:
  - Waveform <= EN ? (raw * VOL) >> 8 : 0.
  - The product is (W+8) bits wide, so there is no overflow.
  - One Clock latency from the phase register.
  - A CTRL change takes effect on the Waveform update following the register commit.

Optional Feature:
- Macro CHANNEL_NOISE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1.
  - Steps on every cycle where carry=1 and EN=1.
  - TYPE 3 raw = lfsr[15 -: W] (zero-extended if W>16 is impossible by range).
- Not defined:
  - No LFSR is present; TYPE 3 raw = 0.

Decomposition:
- Shared package channel_pkg holds:
  - register offset constants (REG_CTRL..REG_SAMPLE);
  - wave type encodings (WAVE_SAW, WAVE_PULSE, WAVE_TRI, WAVE_NOISE);
  - PHASE_W = 24;
  - LFSR_SEED.
- One natural sub-module, channel_bus_if: BusClock synchroniser, edge detect, address decode, tristate read mux.
- Register file, accumulator and shaping stay in channel.

Test Plan:
- Reset behaviour: Reset low with arbitrary bus activity -> Waveform=0, all registers read 8'h00, BusData Z; a write attempted during reset has no effect after release.
- Register read/write: write CTRL=8'h03, FREQ_LO=8'h00, FREQ_HI=8'h01, PW=8'h80, VOL=8'hFF at ADDR 0x0010..0x0014, then read back -> same values. Read 0x0015 -> SAMPLE. Read 0x001F -> 8'h00. Access 0x0020 -> no drive, no effect.
- Saw: INC=16'h0100, VOL=FF, TYPE saw -> phase[23:16] increments every 256 Clocks; Waveform ramps 0..254 (255*255>>8) and wraps to 0.
- Pulse: PW=8'h40 -> Waveform high (8'hFE) for 25% of the period, 0 otherwise. PW=0 -> constant 0.
- Triangle and volume: TYPE=2, VOL=8'h80 -> peak ≈ 8'h7F at mid-period, symmetric fall. EN=0 -> Waveform 0 within 2 cycles, phase frozen; re-enable resumes from the held phase.
- PRST and noise: write CTRL with bit7 -> phase cleared, CTRL bit7 reads 0. With CHANNEL_NOISE_EN defined, TYPE=3 -> first LFSR step from 16'hACE1 gives 16'h5670; without the macro, TYPE=3 -> Waveform 0.
